// File: rtl/olint_multi_v5.sv
// Multi-lane frequency-to-phase integrator with wrap/saturate arithmetic,
// per-lane clear/preload, sticky overflow flags and a decimated phase snapshot.
// Ports:
//   clk, rst (async, active-low)
//   in_valid, ferror[CHANNELS*INPUT_WIDTH]  : per-lane signed frequency error
//   sat_mode                                : 0 wrap, 1 saturate
//   clear, load[CHANNELS], load_value       : per-lane clear / preload
//   ovf_clr                                 : clears all sticky overflow flags
//   perror, out_valid                       : registered decimated snapshot + strobe
//   ovf_flag[CHANNELS]                      : sticky overflow per lane
module olint_multi_v5 #(
  parameter int unsigned CHANNELS          = 4,
  parameter int unsigned INPUT_WIDTH       = 32,
  parameter int unsigned ACCUMULATOR_WIDTH = 32,
  parameter int unsigned DECIM             = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [CHANNELS*INPUT_WIDTH-1:0]       ferror,
  input  logic                                  sat_mode,
  input  logic [CHANNELS-1:0]                   clear,
  input  logic [CHANNELS-1:0]                   load,
  input  logic [CHANNELS*ACCUMULATOR_WIDTH-1:0] load_value,
  input  logic                                  ovf_clr,
  output logic [CHANNELS*ACCUMULATOR_WIDTH-1:0] perror,
  output logic                                  out_valid,
  output logic [CHANNELS-1:0]                   ovf_flag
);

  localparam int unsigned IW = INPUT_WIDTH;
  localparam int unsigned AW = ACCUMULATOR_WIDTH;
  localparam int unsigned CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  logic signed [AW-1:0] r_acc     [CHANNELS];
  logic signed [AW-1:0] w_acc_nxt [CHANNELS];
  logic signed [AW:0]   w_sum     [CHANNELS];
  logic [CHANNELS-1:0]    w_ovf;
  logic [CHANNELS*AW-1:0] w_snap;
  logic [CW-1:0]          r_count;
  logic                   w_strobe;

  // Snapshot fires on the accepted sample that completes a decimation group.
  assign w_strobe = in_valid && (r_count == CW'(DECIM - 1));

  // Per-lane next accumulator: clear > load > accumulate > hold.
  always_comb begin
    w_ovf  = '0;
    w_snap = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      w_sum[k]     = (AW+1)'(r_acc[k]) + (AW+1)'($signed(ferror[k*IW +: IW]));
      w_acc_nxt[k] = r_acc[k];
      if (clear[k]) begin
        w_acc_nxt[k] = '0;
      end else if (load[k]) begin
        w_acc_nxt[k] = load_value[k*AW +: AW];
      end else if (in_valid) begin
        // Top two bits of the widened sum disagree only when out of range.
        w_ovf[k] = w_sum[k][AW] ^ w_sum[k][AW-1];
        if (sat_mode && w_ovf[k]) begin
          w_acc_nxt[k] = w_sum[k][AW] ? ACC_MIN : ACC_MAX;
        end else begin
          w_acc_nxt[k] = w_sum[k][AW-1:0];
        end
      end
      w_snap[k*AW +: AW] = w_acc_nxt[k];
    end
  end

  // Accumulators and sticky flags (set wins over clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        r_acc[k] <= '0;
      end
      ovf_flag <= '0;
    end else begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        r_acc[k] <= w_acc_nxt[k];
      end
      ovf_flag <= (ovf_flag & ~{CHANNELS{ovf_clr}}) | w_ovf;
    end
  end

  // Decimation counter and registered snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= '0;
      perror    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= w_strobe;
      if (w_strobe) begin
        perror  <= w_snap;
        r_count <= '0;
      end else if (in_valid) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_olint_multi_v5.sv
// Bench for olint_multi_v5: two instances (DECIM=1 and DECIM=4) driven with the
// same stimulus and checked every cycle against an integer-arithmetic model,
// plus literal expectations for the directed scenarios.
module tb_olint_multi_v5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        sat_mode = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [15:0] ferror = '0;
  logic [15:0] load_value = '0;
  logic [1:0]  clear = '0;
  logic [1:0]  load = '0;

  logic [15:0] perror_a, perror_b;
  logic        out_valid_a, out_valid_b;
  logic [1:0]  ovf_a, ovf_b;

  int n_total = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  olint_multi_v5 #(.CHANNELS(2), .INPUT_WIDTH(8), .ACCUMULATOR_WIDTH(8), .DECIM(1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ferror(ferror), .sat_mode(sat_mode),
    .clear(clear), .load(load), .load_value(load_value), .ovf_clr(ovf_clr),
    .perror(perror_a), .out_valid(out_valid_a), .ovf_flag(ovf_a));

  olint_multi_v5 #(.CHANNELS(2), .INPUT_WIDTH(8), .ACCUMULATOR_WIDTH(8), .DECIM(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ferror(ferror), .sat_mode(sat_mode),
    .clear(clear), .load(load), .load_value(load_value), .ovf_clr(ovf_clr),
    .perror(perror_b), .out_valid(out_valid_b), .ovf_flag(ovf_b));

  // Reference state: plain integers, shared accumulators, per-instance decimation.
  int      m_acc [2];
  bit [1:0] m_flag;
  int      m_cnt [2];
  int      m_perr [2][2];
  bit      m_ov [2];
  bit [1:0] m_set;
  int      m_s;
  int      m_dec;

  function automatic int lane_s(input logic [15:0] v, input int k);
    logic signed [7:0] t;
    t = v[k*8 +: 8];
    return int'(t);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_ov[i] = 1'b0;
        m_perr[i][0] = 0; m_perr[i][1] = 0;
      end
      m_flag = '0;
    end else begin
      m_set = '0;
      for (int k = 0; k < 2; k++) begin
        if (clear[k]) m_acc[k] = 0;
        else if (load[k]) m_acc[k] = lane_s(load_value, k);
        else if (in_valid) begin
          m_s = m_acc[k] + lane_s(ferror, k);
          if (m_s > 127 || m_s < -128) begin
            m_set[k] = 1'b1;
            if (sat_mode) m_s = (m_s > 127) ? 127 : -128;
            else          m_s = (m_s > 127) ? m_s - 256 : m_s + 256;
          end
          m_acc[k] = m_s;
        end
      end
      m_flag = (m_flag & ~{2{ovf_clr}}) | m_set;
      for (int i = 0; i < 2; i++) begin
        m_dec = (i == 0) ? 1 : 4;
        m_ov[i] = 1'b0;
        if (in_valid) begin
          if (m_cnt[i] == m_dec - 1) begin
            m_ov[i] = 1'b1;
            m_cnt[i] = 0;
            m_perr[i][0] = m_acc[0];
            m_perr[i][1] = m_acc[1];
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
    end
  end

  task automatic cmp(input string nm, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        cmp($sformatf("perror_a[%0d]", k), lane_s(perror_a, k), m_perr[0][k]);
        cmp($sformatf("perror_b[%0d]", k), lane_s(perror_b, k), m_perr[1][k]);
      end
      cmp("out_valid_a", int'(out_valid_a), int'(m_ov[0]));
      cmp("out_valid_b", int'(out_valid_b), int'(m_ov[1]));
      cmp("ovf_flag_a", int'(ovf_a), int'(m_flag));
      cmp("ovf_flag_b", int'(ovf_b), int'(m_flag));
    end
  end

  // Apply inputs just after a falling edge, then advance to the next falling edge.
  task automatic step(input bit iv, input int f0, input int f1, input bit sat,
                      input logic [1:0] clr, input logic [1:0] ld,
                      input int l0, input int l1, input bit oc);
    in_valid   = iv;
    ferror     = {8'(f1), 8'(f0)};
    sat_mode   = sat;
    clear      = clr;
    load       = ld;
    load_value = {8'(l1), 8'(l0)};
    ovf_clr    = oc;
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    // Reset state
    cmp("rst_perror_a", int'(perror_a), 0);
    cmp("rst_out_valid_b", int'(out_valid_b), 0);
    cmp("rst_ovf_a", int'(ovf_a), 0);
    rst = 1'b1;
    step(1'b0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 16)) - 8,
           int'($urandom_range(0, 255)),
           $urandom_range(0, 1) != 0,
           ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
           ($urandom_range(0, 11) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           $urandom_range(0, 9) == 0);
    end

    // Asynchronous reset between edges
    step(1'b1, 5, 7, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    cmp("async_perror_a", int'(perror_a), 0);
    cmp("async_perror_b", int'(perror_b), 0);
    cmp("async_out_valid_a", int'(out_valid_a), 0);
    cmp("async_out_valid_b", int'(out_valid_b), 0);
    cmp("async_ovf_a", int'(ovf_a), 0);
    cmp("async_ovf_b", int'(ovf_b), 0);
    @(negedge clk);
    step(1'b0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
    rst = 1'b1;

    // Decimation by 4 with a gap: strobe after the 4th accepted sample
    step(1'b1, 1, 0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
    step(1'b1, 1, 0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
    cmp("dec_no_strobe_2", int'(out_valid_b), 0);
    step(1'b0, 1, 0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
    cmp("dec1_idle", int'(out_valid_a), 0);
    step(1'b1, 1, 0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
    cmp("dec1_strobe", int'(out_valid_a), 1);
    cmp("dec_no_strobe_3", int'(out_valid_b), 0);
    step(1'b1, 1, 0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
    cmp("dec_strobe", int'(out_valid_b), 1);
    cmp("dec_perror0", lane_s(perror_b, 0), 4);
    step(1'b0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
    cmp("dec_strobe_drop", int'(out_valid_b), 0);
    cmp("dec_perror_hold", lane_s(perror_b, 0), 4);

    // Wrap: 120 + 10 -> -126, lane1 untouched
    step(1'b0, 0, 0, 1'b0, 2'b00, 2'b11, 120, 17, 1'b1);
    step(1'b1, 10, 0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
    cmp("wrap_lane0", lane_s(perror_a, 0), -126);
    cmp("wrap_lane1", lane_s(perror_a, 1), 17);
    cmp("wrap_flags", int'(ovf_a), 1);

    // Saturate both directions, then an in-range add
    step(1'b0, 0, 0, 1'b1, 2'b00, 2'b11, 120, -120, 1'b1);
    step(1'b1, 10, -10, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0);
    cmp("sat_pos", lane_s(perror_a, 0), 127);
    cmp("sat_neg", lane_s(perror_a, 1), -128);
    cmp("sat_flags", int'(ovf_a), 3);
    step(1'b0, 0, 0, 1'b1, 2'b00, 2'b01, 100, 0, 1'b1);
    cmp("sat_flags_clr", int'(ovf_a), 0);
    step(1'b1, 10, 0, 1'b1, 2'b00, 2'b00, 0, 0, 1'b0);
    cmp("sat_inrange", lane_s(perror_a, 0), 110);
    cmp("sat_inrange_flag", int'(ovf_a), 0);

    // Priority: clear beats load beats accumulate
    step(1'b1, 1, 5, 1'b0, 2'b10, 2'b10, 0, 8'h50, 1'b0);
    cmp("prio_lane0", lane_s(perror_a, 0), 111);
    cmp("prio_clear", lane_s(perror_a, 1), 0);
    step(1'b1, 0, 5, 1'b0, 2'b00, 2'b10, 0, 8'h50, 1'b0);
    cmp("prio_load", lane_s(perror_a, 1), 8'h50);
    step(1'b1, 0, 3, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
    cmp("prio_acc", lane_s(perror_a, 1), 8'h53);

    // Overflow set wins over a simultaneous ovf_clr
    step(1'b0, 0, 0, 1'b0, 2'b00, 2'b01, 127, 0, 1'b1);
    cmp("ovc_pre", int'(ovf_a), 0);
    step(1'b1, 1, 0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b1);
    cmp("ovc_set_wins", int'(ovf_a), 1);
    cmp("ovc_wrap", lane_s(perror_a, 0), -128);
    step(1'b0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b1);
    cmp("ovc_cleared", int'(ovf_a), 0);

    step(1'b0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0);
    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
